pipe_ctrl_fsm: RTL and testbench

//  - Central pipeline sequencer for the 5-stage core. Merges the combinational load-use

---
 rtl/pipe_ctrl_fsm_pkg.sv | 53 +++++
 rtl/pipe_ctrl_fsm_dmem_watchdog.sv | 30 +++
 rtl/pipe_ctrl_fsm.sv | 137 +++++++++++++
 tb/tb_pipe_ctrl_fsm.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_fsm_pkg.sv
// Shared definitions for the pipeline sequencer: FSM state encoding, the
// NOP word the datapath flush muxes load, and the stage-control bundle.
package pipe_ctrl_fsm_pkg;

  // Sequencer state: normal issue, or frozen waiting on D-mem.
  typedef enum logic {
    PCS_RUN   = 1'b0,
    PCS_DWAIT = 1'b1
  } pcs_e;

  // Encoding loaded by the pipeline-register flush muxes (addi x0,x0,0).
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  // Per-stage control bundle driven by the sequencer every cycle.
  typedef struct packed {
    logic pc_we;
    logic pc_redirect;
    logic if_id_we;
    logic if_id_flush;
    logic id_ex_we;
    logic id_ex_flush;
    logic ex_mem_we;
    logic mem_wb_we;
    logic mem_wb_flush;
  } pipe_ctl_t;

  // Everything advances, nothing is squashed.
  localparam pipe_ctl_t CTL_RUN = '{
    pc_we:        1'b1,
    pc_redirect:  1'b0,
    if_id_we:     1'b1,
    if_id_flush:  1'b0,
    id_ex_we:     1'b1,
    id_ex_flush:  1'b0,
    ex_mem_we:    1'b1,
    mem_wb_we:    1'b1,
    mem_wb_flush: 1'b0
  };

  // Before the first post-reset edge: nothing writes, every stage holds a NOP.
  localparam pipe_ctl_t CTL_RESET = '{
    pc_we:        1'b0,
    pc_redirect:  1'b0,
    if_id_we:     1'b0,
    if_id_flush:  1'b1,
    id_ex_we:     1'b0,
    id_ex_flush:  1'b1,
    ex_mem_we:    1'b0,
    mem_wb_we:    1'b0,
    mem_wb_flush: 1'b1
  };

endpackage

// File: rtl/pipe_ctrl_fsm_dmem_watchdog.sv
// D-mem wait watchdog: counts consecutive wait cycles and pulses dmem_timeout
// once, on the DMEM_TIMEOUT-th wait cycle. The counter saturates one past the
// pulse point so a long stall cannot re-trigger it by wrapping.
module pipe_dmem_watchdog #(
  parameter int DMEM_TIMEOUT = 256,
  parameter int TO_W         = 9
) (
  input  logic clk,
  input  logic rst_n,
  input  logic waiting,    // qualified D-mem wait this cycle
  input  logic in_dwait,   // sequencer already in DWAIT state
  output logic dmem_timeout
);

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(DMEM_TIMEOUT - 1);
  localparam logic [TO_W-1:0] TO_SAT  = TO_W'(DMEM_TIMEOUT);

  logic [TO_W-1:0] to_cnt;

  // Count wait cycles; any non-wait cycle (DWAIT exit) clears the count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              to_cnt <= '0;
    else if (!waiting)       to_cnt <= '0;
    else if (to_cnt != TO_SAT) to_cnt <= to_cnt + 1'b1;
  end

  // First wait cycle is seen in RUN with to_cnt=0, so the N-th is at N-1.
  assign dmem_timeout = waiting & in_dwait & (to_cnt == TO_LAST);

endmodule

// File: rtl/pipe_ctrl_fsm.sv
// Central sequencer for the 5-stage core. Merges D-mem wait, EX redirect,
// load-use stall and I-mem fetch wait into per-stage write-enable / flush
// controls and the PC update strobe. Decisions are combinational from state
// and inputs and take effect at the next edge.
// Optional feature macro: PIPE_PERF_EN adds stall/redirect perf counters.
module pipe_ctrl_fsm
  import pipe_ctrl_fsm_pkg::*;
#(
  parameter int DMEM_TIMEOUT = 256,
  parameter int TO_W         = 9
`ifdef PIPE_PERF_EN
  ,
  parameter int PERF_W       = 32
`endif
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load_use_stall,
  input  logic ex_redirect,
  input  logic mem_req,
  input  logic dmem_ready,
  input  logic imem_ready,
  output logic pc_we,
  output logic pc_redirect,
  output logic if_id_we,
  output logic if_id_flush,
  output logic id_ex_we,
  output logic id_ex_flush,
  output logic ex_mem_we,
  output logic mem_wb_we,
  output logic mem_wb_flush,
  output logic dmem_timeout
`ifdef PIPE_PERF_EN
  ,
  output logic [PERF_W-1:0] perf_stall_cnt,
  output logic [PERF_W-1:0] perf_flush_cnt
`endif
);

  pcs_e      state, state_nxt;
  logic      drain, drain_nxt;
  logic      started;
  logic      dwait;
  pipe_ctl_t ctl;

  assign dwait = mem_req & ~dmem_ready;

  // State register; started marks the first edge after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= PCS_RUN;
      drain   <= 1'b0;
      started <= 1'b0;
    end else begin
      state   <= state_nxt;
      drain   <= drain_nxt;
      started <= 1'b1;
    end
  end

  // Next state and stage controls, priority: dwait > redirect > stall > fetch.
  always_comb begin
    ctl       = CTL_RUN;
    state_nxt = PCS_RUN;
    drain_nxt = drain;
    if (!started) begin
      ctl       = CTL_RESET;
      drain_nxt = 1'b0;
    end else if (dwait) begin
      // Freeze everything up to MEM; WB gets a bubble. A redirect or stall
      // in EX/ID is held in place and will be presented again later.
      ctl.pc_we        = 1'b0;
      ctl.if_id_we     = 1'b0;
      ctl.id_ex_we     = 1'b0;
      ctl.ex_mem_we    = 1'b0;
      ctl.mem_wb_flush = 1'b1;
      state_nxt        = PCS_DWAIT;
    end else begin
      // A returning fetch while draining is the wrong-path one: drop it.
      if (imem_ready) drain_nxt = 1'b0;
      if (ex_redirect) begin
        ctl.pc_redirect = 1'b1;
        ctl.if_id_flush = 1'b1;
        ctl.id_ex_flush = 1'b1;
        // Fetch still outstanding means it belongs to the old path.
        drain_nxt       = ~imem_ready;
      end else if (load_use_stall) begin
        ctl.pc_we       = 1'b0;
        ctl.if_id_we    = 1'b0;
        ctl.id_ex_flush = 1'b1;
      end else if (!imem_ready || drain) begin
        // Either no fetch yet, or the fetch is wrong-path: bubble into ID
        // and hold PC so the (target) fetch is reissued.
        ctl.pc_we       = 1'b0;
        ctl.if_id_flush = 1'b1;
      end
    end
  end

  assign pc_we        = ctl.pc_we;
  assign pc_redirect  = ctl.pc_redirect;
  assign if_id_we     = ctl.if_id_we;
  assign if_id_flush  = ctl.if_id_flush;
  assign id_ex_we     = ctl.id_ex_we;
  assign id_ex_flush  = ctl.id_ex_flush;
  assign ex_mem_we    = ctl.ex_mem_we;
  assign mem_wb_we    = ctl.mem_wb_we;
  assign mem_wb_flush = ctl.mem_wb_flush;

  pipe_dmem_watchdog #(
    .DMEM_TIMEOUT (DMEM_TIMEOUT),
    .TO_W         (TO_W)
  ) u_wdog (
    .clk          (clk),
    .rst_n        (rst_n),
    .waiting      (started & dwait),
    .in_dwait     (state == PCS_DWAIT),
    .dmem_timeout (dmem_timeout)
  );

`ifdef PIPE_PERF_EN
  logic redirect_acc;
  assign redirect_acc = started & ~dwait & ex_redirect;

  // Free-running perf counters: cycles without PC advance, accepted redirects.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_stall_cnt <= '0;
      perf_flush_cnt <= '0;
    end else begin
      if (started && !ctl.pc_we) perf_stall_cnt <= perf_stall_cnt + 1'b1;
      if (redirect_acc)          perf_flush_cnt <= perf_flush_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_ctrl_fsm.sv
// Directed bench for pipe_ctrl_fsm (DMEM_TIMEOUT=4). Control outputs are
// compared as one vector:
// {pc_we,pc_redirect,if_id_we,if_id_flush,id_ex_we,id_ex_flush,
//  ex_mem_we,mem_wb_we,mem_wb_flush,dmem_timeout}
module tb_pipe_ctrl_fsm;

  localparam logic [9:0] V_RESET = 10'b0001010010;
  localparam logic [9:0] V_RUN   = 10'b1010101100;
  localparam logic [9:0] V_STALL = 10'b0000111100;
  localparam logic [9:0] V_DWAIT = 10'b0000000110;
  localparam logic [9:0] V_DW_TO = 10'b0000000111;
  localparam logic [9:0] V_REDIR = 10'b1111111100;
  localparam logic [9:0] V_FWAIT = 10'b0011101100;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic load_use_stall = 1'b0, ex_redirect = 1'b0, mem_req = 1'b0;
  logic dmem_ready = 1'b1, imem_ready = 1'b1;
  logic pc_we, pc_redirect, if_id_we, if_id_flush, id_ex_we, id_ex_flush;
  logic ex_mem_we, mem_wb_we, mem_wb_flush, dmem_timeout;
`ifdef PIPE_PERF_EN
  logic [31:0] perf_stall_cnt, perf_flush_cnt;
`endif
  logic [9:0] ctl;
  int n_chk = 0;
  int n_pass = 0;

  assign ctl = {pc_we, pc_redirect, if_id_we, if_id_flush, id_ex_we, id_ex_flush,
                ex_mem_we, mem_wb_we, mem_wb_flush, dmem_timeout};

  always #5 clk = ~clk;

  pipe_ctrl_fsm #(.DMEM_TIMEOUT(4), .TO_W(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .load_use_stall(load_use_stall), .ex_redirect(ex_redirect),
    .mem_req(mem_req), .dmem_ready(dmem_ready), .imem_ready(imem_ready),
    .pc_we(pc_we), .pc_redirect(pc_redirect),
    .if_id_we(if_id_we), .if_id_flush(if_id_flush),
    .id_ex_we(id_ex_we), .id_ex_flush(id_ex_flush),
    .ex_mem_we(ex_mem_we), .mem_wb_we(mem_wb_we), .mem_wb_flush(mem_wb_flush),
    .dmem_timeout(dmem_timeout)
`ifdef PIPE_PERF_EN
    , .perf_stall_cnt(perf_stall_cnt), .perf_flush_cnt(perf_flush_cnt)
`endif
  );

  // Apply one cycle of inputs at the falling edge; outputs settle 1ns later.
  task automatic drive(input logic lus, input logic red, input logic mreq,
                       input logic dr, input logic ir);
    @(negedge clk);
    load_use_stall = lus; ex_redirect = red; mem_req = mreq;
    dmem_ready = dr; imem_ready = ir;
    #1;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    #1;
    n_chk++; if (ctl !== V_RESET) $display("FAIL reset_hold: got %b exp %b", ctl, V_RESET); else n_pass++;
    @(negedge clk); rst_n = 1'b1; #1;
    n_chk++; if (ctl !== V_RESET) $display("FAIL reset_cyc0: got %b exp %b", ctl, V_RESET); else n_pass++;
    drive(0, 0, 0, 1, 1);
    n_chk++; if (ctl !== V_RUN) $display("FAIL reset_cyc1: got %b exp %b", ctl, V_RUN); else n_pass++;
  endtask

  task automatic test_load_use();
    drive(1, 0, 0, 1, 1);
    n_chk++; if (ctl !== V_STALL) $display("FAIL lu_stall: got %b exp %b", ctl, V_STALL); else n_pass++;
    drive(0, 0, 0, 1, 1);
    n_chk++; if (ctl !== V_RUN) $display("FAIL lu_after: got %b exp %b", ctl, V_RUN); else n_pass++;
  endtask

  // 4 wait cycles, redirect raised in cycle 2 and held until D-mem completes.
  task automatic test_dwait_redirect();
    for (int i = 1; i <= 4; i++) begin
      drive(0, (i >= 2), 1, 0, 1);
      n_chk++;
      if (ctl !== ((i == 4) ? V_DW_TO : V_DWAIT))
        $display("FAIL dwait_cyc%0d: got %b exp %b", i, ctl, (i == 4) ? V_DW_TO : V_DWAIT);
      else n_pass++;
    end
    drive(0, 1, 1, 1, 1);
    n_chk++; if (ctl !== V_REDIR) $display("FAIL dwait_redir: got %b exp %b", ctl, V_REDIR); else n_pass++;
    drive(0, 0, 0, 1, 1);
    n_chk++; if (ctl !== V_RUN) $display("FAIL dwait_after: got %b exp %b", ctl, V_RUN); else n_pass++;
  endtask

  task automatic test_drain();
    drive(0, 1, 0, 1, 0);
    n_chk++; if (ctl !== V_REDIR) $display("FAIL drain_redir: got %b exp %b", ctl, V_REDIR); else n_pass++;
    drive(0, 0, 0, 1, 0);
    n_chk++; if (ctl !== V_FWAIT) $display("FAIL drain_wait: got %b exp %b", ctl, V_FWAIT); else n_pass++;
    drive(0, 0, 0, 1, 1);
    n_chk++; if (ctl !== V_FWAIT) $display("FAIL drain_drop: got %b exp %b", ctl, V_FWAIT); else n_pass++;
    drive(0, 0, 0, 1, 1);
    n_chk++; if (ctl !== V_RUN) $display("FAIL drain_done: got %b exp %b", ctl, V_RUN); else n_pass++;
    // New redirect in the draining cycle takes the redirect and leaves drain clear.
    drive(0, 1, 0, 1, 0);
    drive(0, 1, 0, 1, 1);
    n_chk++; if (ctl !== V_REDIR) $display("FAIL drain_reredir: got %b exp %b", ctl, V_REDIR); else n_pass++;
    drive(0, 0, 0, 1, 1);
    n_chk++; if (ctl !== V_RUN) $display("FAIL drain_reredir_after: got %b exp %b", ctl, V_RUN); else n_pass++;
  endtask

  task automatic test_timeout();
    for (int i = 1; i <= 10; i++) begin
      drive(0, 0, 1, 0, 1);
      n_chk++;
      if (ctl !== ((i == 4) ? V_DW_TO : V_DWAIT))
        $display("FAIL timeout_cyc%0d: got %b exp %b", i, ctl, (i == 4) ? V_DW_TO : V_DWAIT);
      else n_pass++;
    end
    drive(0, 0, 0, 1, 1);
    n_chk++; if (ctl !== V_RUN) $display("FAIL timeout_exit: got %b exp %b", ctl, V_RUN); else n_pass++;
  endtask

  // Reset while draining and waiting: no drain, fresh watchdog afterwards.
  task automatic test_reset_mid();
    drive(0, 1, 0, 1, 0);
    drive(0, 0, 1, 0, 0);
    @(negedge clk); rst_n = 1'b0; mem_req = 1'b0; dmem_ready = 1'b1; imem_ready = 1'b1; #1;
    n_chk++; if (ctl !== V_RESET) $display("FAIL rmid_async: got %b exp %b", ctl, V_RESET); else n_pass++;
    @(negedge clk); rst_n = 1'b1;
    drive(0, 0, 0, 1, 1);
    n_chk++; if (ctl !== V_RUN) $display("FAIL rmid_nodrain: got %b exp %b", ctl, V_RUN); else n_pass++;
    for (int i = 1; i <= 4; i++) begin
      drive(0, 0, 1, 0, 1);
      n_chk++;
      if (ctl !== ((i == 4) ? V_DW_TO : V_DWAIT))
        $display("FAIL rmid_wait%0d: got %b exp %b", i, ctl, (i == 4) ? V_DW_TO : V_DWAIT);
      else n_pass++;
    end
    drive(0, 0, 0, 1, 1);
  endtask

`ifdef PIPE_PERF_EN
  task automatic test_perf();
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    repeat (3) drive(1, 0, 0, 1, 1);
    repeat (2) drive(0, 1, 0, 1, 1);
    drive(0, 0, 0, 1, 1);
    n_chk++; if (perf_stall_cnt !== 32'd3) $display("FAIL perf_stall: got %0d exp 3", perf_stall_cnt); else n_pass++;
    n_chk++; if (perf_flush_cnt !== 32'd2) $display("FAIL perf_flush: got %0d exp 2", perf_flush_cnt); else n_pass++;
    @(negedge clk); rst_n = 1'b0; #1;
    n_chk++; if (perf_stall_cnt !== 32'd0) $display("FAIL perf_stall_rst: got %0d exp 0", perf_stall_cnt); else n_pass++;
    n_chk++; if (perf_flush_cnt !== 32'd0) $display("FAIL perf_flush_rst: got %0d exp 0", perf_flush_cnt); else n_pass++;
    @(negedge clk); rst_n = 1'b1;
  endtask
`endif

  initial begin
    test_reset();
    test_load_use();
    test_dwait_redirect();
    test_drain();
    test_timeout();
    test_reset_mid();
`ifdef PIPE_PERF_EN
    test_perf();
`endif
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
